// File: rtl/seq_pattern_detector.sv
// ----------------------------------------------------------------------------
// seq_pattern_detector
//
// Moore serial-pattern detector with a run-time loadable PAT_W-bit pattern.
// Bits arrive MSB-first on data_in and are taken only while en=1. A fill
// counter holds the detector off until PAT_W valid bits are in the history.
// The OVERLAP parameter chooses what happens after a match: with OVERLAP=1
// the history is kept, so overlapping matches are found. With OVERLAP=0 the
// history restarts after each match. Matches are counted in a saturating
// counter.
//
// Ports
//   clk          rising-edge system clock
//   reset        asynchronous active-low reset
//   en           sample enable for data_in
//   data_in      serial data, MSB of the pattern first
//   pat_load     load pat_in as the new pattern (restarts the history)
//   pat_in       new pattern value
//   cnt_clr      synchronous clear of match_count (wins over a hit)
//   data_out     registered one-cycle match flag
//   match_count  saturating number of matches
//   count_sat    match_count is all ones
// ----------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter int               OVERLAP = 1,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1011)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             data_in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             data_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // FILL while the history is still being primed, ARMED once it holds
  // PAT_W valid samples.
  typedef enum logic {
    FILL,
    ARMED
  } phase_e;

  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              data_out_q, data_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  phase_e            phase;
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              hit;
  logic              hit_taken;

  // Speculative shift/fill values for an enabled sample. They are only used
  // when en=1 and pat_load=0, so an unknown data_in while idle never reaches
  // the state.
  always_comb begin
    phase  = (fill_q == FILL_FULL) ? ARMED : FILL;
    // The cast drops the oldest bit of the shifted history.
    hist_n = PAT_W'({hist_q, data_in});
    fill_n = (phase == ARMED) ? FILL_FULL : fill_q + 1'b1;
    hit    = (fill_n == FILL_FULL) && (hist_n == pattern_q);
  end

  assign hit_taken = en && !pat_load && hit;

  // Next-state logic, in priority order: pattern load, enabled sample, idle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    pattern_d  = pattern_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    data_out_d = 1'b0;

    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (en) begin
      hist_d     = hist_n;
      data_out_d = hit;
      fill_d     = (hit && (OVERLAP == 0)) ? '0 : fill_n;
    end
  end

  // A clear takes priority over a hit on the same edge. The hit still
  // pulses data_out but is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit_taken && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, whatever the statement order.
    if (!reset) begin
      pattern_q  <= DEF_PAT;
      hist_q     <= '0;
      fill_q     <= '0;
      data_out_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pattern_q  <= pattern_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
    end
  end

  assign data_out    = data_out_q;
  assign match_count = cnt_q;
  assign count_sat   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// ----------------------------------------------------------------------------
// Bench for seq_pattern_detector. Three instances share one stimulus stream:
//   cfg0: OVERLAP=1, CNT_W=8
//   cfg1: OVERLAP=0, CNT_W=8
//   cfg2: OVERLAP=1, CNT_W=2
// The reference model keeps a log of every sampled bit. For each config it
// also keeps the log index where the current history began. A match is
// "the last PAT_W logged bits since that index equal the pattern".
// ----------------------------------------------------------------------------
module tb_seq_pattern_detector;

  logic       clk;
  logic       reset;
  logic       en;
  logic       data_in;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic       dout_a, dout_b, dout_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic       sat_a, sat_b, sat_c;

  seq_pattern_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(1), .DEF_PAT(4'b1011)) dut_a (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .data_out(dout_a), .match_count(cnt_a),
    .count_sat(sat_a)
  );
  seq_pattern_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(0), .DEF_PAT(4'b1011)) dut_b (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .data_out(dout_b), .match_count(cnt_b),
    .count_sat(sat_b)
  );
  seq_pattern_detector #(.PAT_W(4), .CNT_W(2), .OVERLAP(1), .DEF_PAT(4'b1011)) dut_c (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .data_out(dout_c), .match_count(cnt_c),
    .count_sat(sat_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         sample_log[$];
  logic [3:0] m_pattern;
  int         m_start[3];
  int         m_cnt[3];
  bit         m_dout[3];
  bit         m_ovl[3]  = '{1'b1, 1'b0, 1'b1};
  int         m_cmax[3] = '{255, 255, 3};

  task automatic model_reset();
    m_pattern = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      m_start[k] = sample_log.size();
      m_cnt[k]   = 0;
      m_dout[k]  = 1'b0;
    end
  endtask

  // Last four logged bits (MSB first) equal the pattern, with at least four
  // bits logged since the history of config k began.
  function automatic bit window_match(int k);
    int n;
    n = sample_log.size();
    if (n - m_start[k] < 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sample_log[n - 4 + i] != m_pattern[3 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit e, input bit d, input bit ld,
                            input logic [3:0] pin, input bit clr);
    bit hit;
    if (!ld && e) sample_log.push_back(d);
    for (int k = 0; k < 3; k++) begin
      hit = 1'b0;
      if (ld) begin
        m_start[k] = sample_log.size();
      end else if (e) begin
        hit = window_match(k);
        if (hit && !m_ovl[k]) m_start[k] = sample_log.size();
      end
      m_dout[k] = hit;
      if (clr) m_cnt[k] = 0;
      else if (hit && m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
    end
    if (ld) m_pattern = pin;
  endtask

  // ---------------- per-cycle comparison ----------------
  logic dout_arr[3];
  int   cnt_arr[3];
  logic sat_arr[3];
  assign dout_arr[0] = dout_a;
  assign dout_arr[1] = dout_b;
  assign dout_arr[2] = dout_c;
  assign cnt_arr[0]  = int'(cnt_a);
  assign cnt_arr[1]  = int'(cnt_b);
  assign cnt_arr[2]  = int'(cnt_c);
  assign sat_arr[0]  = sat_a;
  assign sat_arr[1]  = sat_b;
  assign sat_arr[2]  = sat_c;

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("cfg%0d_data_out", k), int'(dout_arr[k]), int'(m_dout[k]));
        check($sformatf("cfg%0d_match_count", k), cnt_arr[k], m_cnt[k]);
        check($sformatf("cfg%0d_count_sat", k), int'(sat_arr[k]),
              int'(m_cnt[k] == m_cmax[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change 1 time unit after a rising edge; the model advances on the
  // edge that consumes them.
  task automatic step(input bit e, input bit d, input bit ld = 1'b0,
                      input logic [3:0] pin = 4'b0000, input bit clr = 1'b0);
    en = e; data_in = d; pat_load = ld; pat_in = pin; cnt_clr = clr;
    @(posedge clk);
    model_step(e, d, ld, pin, clr);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; en = 1'b0; data_in = 1'b0; pat_load = 1'b0;
    pat_in = 4'b0000; cnt_clr = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    check("reset_data_out", int'(dout_a), 0);
    check("reset_count", int'(cnt_a), 0);

    // Stream 1,0,1,1,0,1,1: overlap pulses after bits 4 and 7, non-overlap once.
    feed(32'b101, 3);
    step(1'b1, 1'b1);
    check("t1_pulse4_ovl", int'(dout_a), 1);
    check("t1_pulse4_novl", int'(dout_b), 1);
    feed(32'b01, 2);
    check("t1_no_pulse6", int'(dout_a), 0);
    step(1'b1, 1'b1);
    check("t1_pulse7_ovl", int'(dout_a), 1);
    check("t1_pulse7_novl", int'(dout_b), 0);
    check("t1_count_ovl", int'(cnt_a), 2);
    check("t1_count_novl", int'(cnt_b), 1);

    // Pattern 1111 loaded with a count clear, then six ones.
    step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
    check("t2_load_no_pulse", int'(dout_a), 0);
    feed(32'b111111, 6);
    check("t2_count_ovl", int'(cnt_a), 3);
    check("t2_count_novl", int'(cnt_b), 1);
    check("t2_last_high_ovl", int'(dout_a), 1);
    check("t2_sat_cnt2", int'(sat_c), 1);

    // Enable gap with data toggling.
    do_reset();
    feed(32'b10, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0]);
      check("t3_gap_low", int'(dout_a), 0);
    end
    step(1'b1, 1'b1);
    check("t3_no_early", int'(dout_a), 0);
    step(1'b1, 1'b1);
    check("t3_pulse", int'(dout_a), 1);
    check("t3_count", int'(cnt_a), 1);

    // Saturation with CNT_W=2, then a clear on the same edge as a hit.
    do_reset();
    feed(32'b1011, 4);
    for (int i = 0; i < 6; i++) feed(32'b011, 3);
    check("t4_count_sat_val", int'(cnt_c), 3);
    check("t4_count_sat_flag", int'(sat_c), 1);
    check("t4_count_wide", int'(cnt_a), 7);
    feed(32'b01, 2);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    check("t4_clr_count", int'(cnt_c), 0);
    check("t4_clr_pulse", int'(dout_c), 1);

    // Mid-stream reset drops the partial history and restores 1011.
    do_reset();
    feed(32'b101, 3);
    do_reset();
    step(1'b1, 1'b1);
    check("t5_no_pulse", int'(dout_a), 0);
    check("t5_count", int'(cnt_a), 0);
    check("t5_sat", int'(sat_a), 0);
    feed(32'b011, 3);
    check("t5_default_pattern", int'(dout_a), 1);

    // Pattern load: the bit on the load edge is not sampled.
    do_reset();
    feed(32'b101, 3);
    step(1'b1, 1'b1, 1'b1, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i != 0));
      check("t6_no_pulse", int'(dout_a), 0);
    end
    step(1'b1, 1'b0);
    check("t6_pulse", int'(dout_a), 1);
    check("t6_pulse_novl", int'(dout_b), 1);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 63) == 0, 4'($urandom_range(0, 15)),
             $urandom_range(0, 47) == 0);
      end
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
